// File: rtl/vga_sync_timing.sv
// vga_sync_timing
//   Locks onto the frame-cycle count stream from the vertical counter
//   (two Clk per pixel plus one extra hold cycle per frame) and derives the
//   VGA timing signals. The count is tracked cycle by cycle. Any deviation
//   from the expected sequence drops lock and raises sync_err for one cycle.
//   Lock is regained at the next count of zero.
// Ports
//   Clk          in   clock
//   Reset        in   synchronous, active-high reset
//   cntVertical  in   frame-cycle count, 0..FRAME_LAST
//   pixel_tick   out  pixel_x/pixel_y advanced this cycle
//   pixel_x      out  horizontal position 0..H_TOT-1
//   pixel_y      out  vertical position 0..V_TOT-1
//   hsync        out  active-low horizontal sync
//   vsync        out  active-low vertical sync
//   video_on     out  inside the visible area
//   frame_start  out  one-cycle pulse, count 0 sampled while locked or locking
//   sync_err     out  one-cycle pulse, lock lost
// All outputs are registered: the values at cycle t+1 reflect cntVertical
// as it was sampled at cycle t.
module vga_sync_timing #(
  parameter int CNT_W      = 20,
  parameter int FRAME_LAST = 840000,
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [CNT_W-1:0] cntVertical,
  output logic             pixel_tick,
  output logic [9:0]       pixel_x,
  output logic [9:0]       pixel_y,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             frame_start,
  output logic             sync_err
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(FRAME_LAST);
  localparam logic [9:0]       H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0]       V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0]       H_VISL = 10'(H_VIS);
  localparam logic [9:0]       V_VISL = 10'(V_VIS);
  localparam logic [9:0]       HS_LO  = 10'(H_VIS + H_FP);
  localparam logic [9:0]       HS_HI  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0]       VS_LO  = 10'(V_VIS + V_FP);
  localparam logic [9:0]       VS_HI  = 10'(V_VIS + V_FP + V_SYNC - 1);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] expCnt, expNext;
  logic [9:0]       hNext, vNext;
  logic             tickNext, fsNext, errNext;
  logic             hsyncNext, vsyncNext, videoNext;
  logic             lockNext;

  // pixel_x/pixel_y are the h/v counters themselves.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= UNLOCKED;
      expCnt      <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
    end else begin
      state       <= stateNext;
      expCnt      <= expNext;
      pixel_x     <= hNext;
      pixel_y     <= vNext;
      pixel_tick  <= tickNext;
      frame_start <= fsNext;
      sync_err    <= errNext;
      hsync       <= hsyncNext;
      vsync       <= vsyncNext;
      video_on    <= videoNext;
    end
  end

  always_comb begin
    stateNext = state;
    expNext   = expCnt;
    hNext     = pixel_x;
    vNext     = pixel_y;
    tickNext  = 1'b0;
    fsNext    = 1'b0;
    errNext   = 1'b0;
    case (state)
      UNLOCKED: begin
        hNext = '0;
        vNext = '0;
        if (cntVertical == '0) begin
          stateNext = LOCKED;
          expNext   = CNT_W'(1);
          tickNext  = 1'b1;
          fsNext    = 1'b1;
        end
      end
      LOCKED: begin
        if (cntVertical != expCnt) begin
          stateNext = UNLOCKED;
          errNext   = 1'b1;
          hNext     = '0;
          vNext     = '0;
        end else begin
          expNext = (expCnt == LAST) ? '0 : expCnt + CNT_W'(1);
          // Pixels advance on even counts only; the terminal count is the
          // extra hold cycle and leaves h/v at the last pixel.
          if (!cntVertical[0] && cntVertical < LAST) begin
            tickNext = 1'b1;
            if (cntVertical == '0) begin
              hNext  = '0;
              vNext  = '0;
              fsNext = 1'b1;
            end else if (pixel_x == H_LAST) begin
              hNext = '0;
              vNext = (pixel_y == V_LAST) ? '0 : pixel_y + 10'd1;
            end else begin
              hNext = pixel_x + 10'd1;
            end
          end
        end
      end
      default: stateNext = UNLOCKED;
    endcase

    // Decode from the next h/v so the syncs line up with pixel_x/pixel_y;
    // while unlocked every output sits at its reset value.
    lockNext  = (stateNext == LOCKED);
    hsyncNext = !(lockNext && hNext >= HS_LO && hNext <= HS_HI);
    vsyncNext = !(lockNext && vNext >= VS_LO && vNext <= VS_HI);
    videoNext = lockNext && hNext < H_VISL && vNext < V_VISL;
  end

endmodule
